// File: rtl/stream_frame_adapter.sv
// rtl/stream_frame_adapter.sv - beat-stream <-> wide-frame adapter for a frame-based crypto core
// Gathers IN_BEATS input beats into one frame and serialises each OUT_BEATS-beat result frame.
module stream_frame_adapter #(
  parameter int DATA_W    = 64,
  parameter int IN_BEATS  = 12,
  parameter int OUT_BEATS = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [DATA_W-1:0]             i_in_data,
  output logic                          o_frame_valid,
  input  logic                          i_frame_ready,
  output logic [IN_BEATS*DATA_W-1:0]    o_frame_data,
  input  logic                          i_res_valid,
  output logic                          o_res_ready,
  input  logic [OUT_BEATS*DATA_W-1:0]   i_res_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic [DATA_W-1:0]             o_out_data
);

  localparam int IC_W = $clog2(IN_BEATS);
  localparam int OC_W = $clog2(OUT_BEATS);
  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_BEATS - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_BEATS - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} in_state_t;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} out_state_t;

  in_state_t                  in_state, in_state_nxt;
  logic [IC_W-1:0]            in_cnt, in_cnt_nxt, in_slot;
  logic [IN_BEATS*DATA_W-1:0] frame_q;
  logic                       in_fire;

  out_state_t                 out_state, out_state_nxt;
  logic [OC_W-1:0]            out_cnt, out_cnt_nxt, out_slot;
  logic [OUT_BEATS*DATA_W-1:0] res_q;
  logic [DATA_W-1:0]          res_slice [OUT_BEATS];
  logic                       res_fire, out_fire;

  assign in_fire  = i_in_valid && o_in_ready;
  assign res_fire = i_res_valid && o_res_ready;
  assign out_fire = o_out_valid && i_out_ready;

  // ---------------- input side ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_state <= COLLECT;
      in_cnt   <= '0;
    end else begin
      in_state <= in_state_nxt;
      in_cnt   <= in_cnt_nxt;
    end
  end

  always_comb begin
    in_state_nxt = in_state;
    in_cnt_nxt   = in_cnt;
    case (in_state)
      COLLECT: begin
        if (in_fire) begin
          if (in_cnt == IN_LAST) begin
            in_state_nxt = HOLD;
            in_cnt_nxt   = '0;
          end else begin
            in_cnt_nxt = in_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (i_frame_ready) in_state_nxt = COLLECT;
      end
      default: in_state_nxt = COLLECT;
    endcase
  end

  always_comb begin
    o_in_ready    = (in_state == COLLECT);
    o_frame_valid = (in_state == HOLD);
    in_slot       = MSB_FIRST ? (IN_LAST - in_cnt) : in_cnt;
  end

  // Only the addressed slice is written; the rest of the frame holds.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frame_q <= '0;
    end else begin
      for (int i = 0; i < IN_BEATS; i++) begin
        if (in_fire && in_slot == IC_W'(i)) frame_q[i*DATA_W +: DATA_W] <= i_in_data;
      end
    end
  end

  assign o_frame_data = frame_q;

  // ---------------- output side ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_state <= IDLE;
      out_cnt   <= '0;
    end else begin
      out_state <= out_state_nxt;
      out_cnt   <= out_cnt_nxt;
    end
  end

  always_comb begin
    out_state_nxt = out_state;
    out_cnt_nxt   = out_cnt;
    case (out_state)
      IDLE: begin
        if (res_fire) begin
          out_state_nxt = SEND;
          out_cnt_nxt   = '0;
        end
      end
      SEND: begin
        if (out_fire) begin
          if (out_cnt == OUT_LAST) begin
            out_state_nxt = IDLE;
            out_cnt_nxt   = '0;
          end else begin
            out_cnt_nxt = out_cnt + 1'b1;
          end
        end
      end
      default: out_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_res_ready = (out_state == IDLE);
    o_out_valid = (out_state == SEND);
    out_slot    = '0;
    if (out_state == SEND) out_slot = MSB_FIRST ? (OUT_LAST - out_cnt) : out_cnt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q <= '0;
    end else if (res_fire) begin
      res_q <= i_res_data;
    end
  end

  for (genvar g = 0; g < OUT_BEATS; g++) begin : g_res_slice
    assign res_slice[g] = res_q[g*DATA_W +: DATA_W];
  end

  assign o_out_data = res_slice[out_slot];

endmodule

// File: tb/tb_stream_frame_adapter.sv
// tb/tb_stream_frame_adapter.sv - randomized and directed bench for stream_frame_adapter
// Reference model: frames built by shifting beats in; results split into beats by shifting out.
module tb_stream_frame_adapter;

  logic         clk, rst_n;
  logic         in_valid, in_ready, frame_valid, frame_ready;
  logic [63:0]  in_data, out_data;
  logic [767:0] frame_data;
  logic         res_valid, res_ready, out_valid, out_ready;
  logic [511:0] res_data;

  logic         l_in_valid, l_in_ready, l_frame_valid, l_frame_ready;
  logic [7:0]   l_in_data, l_out_data;
  logic [31:0]  l_frame_data;
  logic         l_res_valid, l_res_ready, l_out_valid, l_out_ready;
  logic [15:0]  l_res_data;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int p_in, p_frame, p_res, p_out;

  logic [63:0]  in_q[$];
  logic [767:0] exp_frame_q[$];
  logic [511:0] res_q[$];
  logic [63:0]  exp_out_q[$];
  logic [767:0] acc;
  int           acc_n;

  stream_frame_adapter u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_data(in_data),
    .o_frame_valid(frame_valid), .i_frame_ready(frame_ready), .o_frame_data(frame_data),
    .i_res_valid(res_valid), .o_res_ready(res_ready), .i_res_data(res_data),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data)
  );

  stream_frame_adapter #(.DATA_W(8), .IN_BEATS(4), .OUT_BEATS(2), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(l_in_valid), .o_in_ready(l_in_ready), .i_in_data(l_in_data),
    .o_frame_valid(l_frame_valid), .i_frame_ready(l_frame_ready), .o_frame_data(l_frame_data),
    .i_res_valid(l_res_valid), .o_res_ready(l_res_ready), .i_res_data(l_res_data),
    .o_out_valid(l_out_valid), .i_out_ready(l_out_ready), .o_out_data(l_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input bit counting);
    for (int k = 0; k < 12; k++) in_q.push_back(counting ? 64'(k) : {$urandom, $urandom});
  endtask

  task automatic push_rand_result();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r = {r[479:0], 32'($urandom)};
    res_q.push_back(r);
  endtask

  // One cycle: drive inputs at negedge, compare against the model, then advance the model.
  task automatic cycle();
    bit m_collect, m_idle;
    logic [511:0] r;
    @(negedge clk);
    in_valid    = (in_q.size() != 0) && ($urandom_range(99) < p_in);
    in_data     = (in_q.size() != 0) ? in_q[0] : {$urandom, $urandom};
    frame_ready = ($urandom_range(99) < p_frame);
    res_valid   = (res_q.size() != 0) && ($urandom_range(99) < p_res);
    res_data    = (res_q.size() != 0) ? res_q[0] : '0;
    out_ready   = ($urandom_range(99) < p_out);
    #1;
    m_collect = (exp_frame_q.size() == 0);
    m_idle    = (exp_out_q.size() == 0);
    check("in_ready", 768'(in_ready), 768'(m_collect));
    check("frame_valid", 768'(frame_valid), 768'(!m_collect));
    if (!m_collect) begin
      check("frame_data", frame_data, exp_frame_q[0]);
      if (frame_ready) void'(exp_frame_q.pop_front());
    end
    check("res_ready", 768'(res_ready), 768'(m_idle));
    check("out_valid", 768'(out_valid), 768'(!m_idle));
    if (!m_idle) begin
      check("out_data", 768'(out_data), 768'(exp_out_q[0]));
      if (out_ready) void'(exp_out_q.pop_front());
    end
    if (in_valid && m_collect) begin
      acc = (acc << 64) | 768'(in_q.pop_front());
      acc_n++;
      if (acc_n == 12) begin
        exp_frame_q.push_back(acc);
        acc = '0;
        acc_n = 0;
      end
    end
    if (res_valid && m_idle) begin
      r = res_q.pop_front();
      for (int k = 0; k < 8; k++) exp_out_q.push_back(64'(r >> (64 * (7 - k))));
    end
    cyc++;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int start = cyc;
    while ((in_q.size() + exp_frame_q.size() + res_q.size() + exp_out_q.size()) != 0 &&
           (cyc - start) < max_cycles) cycle();
    check(tag, 768'(in_q.size() + exp_frame_q.size() + res_q.size() + exp_out_q.size()), 768'(0));
  endtask

  task automatic set_p(input int pi, input int pf, input int pr, input int po);
    p_in = pi; p_frame = pf; p_res = pr; p_out = po;
  endtask

  initial begin
    logic [511:0] r;
    logic [7:0] lb [4];
    rst_n = 1'b0;
    in_valid = 0; in_data = '0; frame_ready = 0; res_valid = 0; res_data = '0; out_ready = 0;
    l_in_valid = 0; l_in_data = '0; l_frame_ready = 0; l_res_valid = 0; l_res_data = '0; l_out_ready = 0;
    acc = '0; acc_n = 0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 768'(in_ready), 768'(1));
    check("rst_frame_valid", 768'(frame_valid), 768'(0));
    check("rst_res_ready", 768'(res_ready), 768'(1));
    check("rst_out_valid", 768'(out_valid), 768'(0));
    check("rst_frame_data", frame_data, 768'(0));
    rst_n = 1'b1;

    // Counting frame 0..B back-to-back, core always ready.
    set_p(100, 100, 100, 100);
    push_beats(1'b1);
    drain("drain_count", 40);

    // Core stalls for 20 cycles with the next frame already being offered.
    set_p(100, 0, 100, 100);
    push_beats(1'b0);
    push_beats(1'b0);
    repeat (13) cycle();
    repeat (20) cycle();
    set_p(100, 100, 100, 100);
    drain("drain_stall", 60);

    // Result 1..8 under a toggling downstream ready.
    set_p(100, 100, 100, 50);
    r = '0;
    for (int k = 1; k <= 8; k++) r = {r[447:0], 64'(k)};
    res_q.push_back(r);
    drain("drain_result", 200);

    // Concurrency: with everything ready, results must hide under input collection.
    set_p(100, 100, 100, 100);
    for (int f = 0; f < 3; f++) begin
      push_beats(1'b0);
      push_rand_result();
    end
    drain("drain_concurrent", 45);

    // Random mix of backpressure on all four handshakes.
    for (int f = 0; f < 4; f++) begin
      push_beats(1'b0);
      push_rand_result();
    end
    set_p(30 + $urandom_range(70), 30 + $urandom_range(70), 30 + $urandom_range(70), 30 + $urandom_range(70));
    drain("drain_random", 3000);

    // Mid-frame reset after 5 input beats and 3 output beats.
    set_p(100, 100, 100, 100);
    push_beats(1'b0);
    cycle();
    push_rand_result();
    repeat (4) cycle();
    check("pre_rst_out_valid", 768'(out_valid), 768'(1));
    @(negedge clk);
    in_valid = 0; res_valid = 0; out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_frame_valid", 768'(frame_valid), 768'(0));
    check("arst_out_valid", 768'(out_valid), 768'(0));
    check("arst_in_ready", 768'(in_ready), 768'(1));
    check("arst_res_ready", 768'(res_ready), 768'(1));
    in_q.delete(); exp_frame_q.delete(); res_q.delete(); exp_out_q.delete();
    acc = '0; acc_n = 0;
    @(negedge clk);
    rst_n = 1'b1;
    push_beats(1'b0);
    push_rand_result();
    drain("drain_after_rst", 60);
    @(negedge clk);
    in_valid = 0; res_valid = 0;

    // LSB-first 8-bit instance.
    lb[0] = 8'hA1; lb[1] = 8'hB2; lb[2] = 8'hC3; lb[3] = 8'hD4;
    l_frame_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      l_in_valid = 1'b1;
      l_in_data = lb[k];
      #1 check("lsb_in_ready", 768'(l_in_ready), 768'(1));
    end
    @(negedge clk);
    l_in_valid = 1'b0;
    check("lsb_frame_valid", 768'(l_frame_valid), 768'(1));
    check("lsb_frame_data", 768'(l_frame_data), 768'(32'hD4C3B2A1));
    check("lsb_hold_in_ready", 768'(l_in_ready), 768'(0));
    l_frame_ready = 1'b1;
    @(negedge clk);
    l_frame_ready = 1'b0;
    check("lsb_frame_done", 768'(l_frame_valid), 768'(0));
    check("lsb_in_ready_back", 768'(l_in_ready), 768'(1));
    l_res_valid = 1'b1;
    l_res_data = 16'h5A3C;
    l_out_ready = 1'b1;
    @(negedge clk);
    l_res_valid = 1'b0;
    check("lsb_out_beat0", 768'({l_out_valid, l_out_data}), 768'({1'b1, 8'h3C}));
    @(negedge clk);
    check("lsb_out_beat1", 768'({l_out_valid, l_out_data}), 768'({1'b1, 8'h5A}));
    @(negedge clk);
    check("lsb_out_idle", 768'({l_out_valid, l_res_ready}), 768'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
